// File: rtl/imul_pkg.sv
// Shared widths and payload types for the integer multiplier issue arbiter.
package imul_pkg;

  localparam int unsigned OP_W      = 13;
  localparam int unsigned FLG_W     = 6;
  localparam int unsigned RES_W     = 65;
  // Widest op tag a request can carry; narrower tags are zero-extended.
  localparam int unsigned TAG_MAX_W = 16;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [RES_W-1:0]     a;
    logic [RES_W-1:0]     b;
    logic [TAG_MAX_W-1:0] tag;
  } imul_req_t;

  typedef struct packed {
    logic [RES_W-1:0] res;
    logic [FLG_W-1:0] flg;
  } imul_res_t;

  function automatic int unsigned src_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imul_issue_arb_if.sv
// Issue-port, multiplier and result-consumer signals of the multiplier issue arbiter.
interface imul_issue_arb_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned TAGW = 9
);
  import imul_pkg::*;

  localparam int unsigned SRCW = src_w(NREQ);

  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ*OP_W-1:0]  req_op;
  logic [NREQ*RES_W-1:0] req_A;
  logic [NREQ*RES_W-1:0] req_B;
  logic [NREQ*TAGW-1:0]  req_tag;

  logic                  mul_en;
  logic                  mul_clkEn;
  logic [OP_W-1:0]       mul_op;
  logic [RES_W-1:0]      mul_R;
  logic [RES_W-1:0]      mul_C;
  logic [RES_W-1:0]      mul_res;
  logic [FLG_W-1:0]      mul_flg;

  logic                  out_vld;
  logic                  out_rdy;
  logic [RES_W-1:0]      out_res;
  logic [FLG_W-1:0]      out_flg;
  logic [TAGW-1:0]       out_tag;
  logic [SRCW-1:0]       out_src;
  logic                  busy;

  // Arbiter side.
  modport slave (
    input  req_vld, req_op, req_A, req_B, req_tag, mul_res, mul_flg, out_rdy,
    output req_rdy, mul_en, mul_clkEn, mul_op, mul_R, mul_C,
    output out_vld, out_res, out_flg, out_tag, out_src, busy
  );

  // Issue ports, multiplier and consumer side.
  modport master (
    output req_vld, req_op, req_A, req_B, req_tag, mul_res, mul_flg, out_rdy,
    input  req_rdy, mul_en, mul_clkEn, mul_op, mul_R, mul_C,
    input  out_vld, out_res, out_flg, out_tag, out_src, busy
  );

endinterface

// File: rtl/imul_res_fifo.sv
// DEPTH-entry result FIFO with occupancy count; DEPTH must be a power of two >= 2.
module imul_res_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         vld,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
  assign vld  = (count != '0);
  assign cnt  = count;

endmodule

// File: rtl/imul_issue_arb.sv
// Round-robin issue arbiter sharing one pipelined multiplier, with tag tracking and result FIFO.
// Optional IMUL_ARB_FLUSH_EN adds a flush input that discards in-flight and buffered results.
module imul_issue_arb
  import imul_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned TAGW   = 9,
  parameter int unsigned LAT    = 4,
  parameter int unsigned FDEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef IMUL_ARB_FLUSH_EN
  input  logic               flush,
`endif
  imul_issue_arb_if.slave    bus
);

  localparam int unsigned SRCW = src_w(NREQ);
  localparam int unsigned CNTW = $clog2(FDEPTH + 1);
  localparam int unsigned DATW = RES_W + FLG_W + TAGW + SRCW;

  logic              flush_now;
  logic              run;
  logic [SRCW-1:0]   ptr;
  logic [SRCW-1:0]   ptr_nxt;
  logic [SRCW-1:0]   cand;
  logic [SRCW-1:0]   gnt_idx;
  logic              gnt_any;
  logic              credit_ok;
  logic              grant;
  logic [TAGW-1:0]   sel_tag;
  imul_req_t         reqs [NREQ];

  logic [LAT:0]      pipe_vld;
  logic [TAGW-1:0]   pipe_tag [LAT+1];
  logic [SRCW-1:0]   pipe_src [LAT+1];
  logic [RES_W-1:0]  hold_res;
  logic [CNTW-1:0]   fifo_cnt;
  logic [DATW-1:0]   head;

`ifdef IMUL_ARB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      reqs[i].op  = bus.req_op[i*OP_W +: OP_W];
      reqs[i].a   = bus.req_A[i*RES_W +: RES_W];
      reqs[i].b   = bus.req_B[i*RES_W +: RES_W];
      reqs[i].tag = TAG_MAX_W'(bus.req_tag[i*TAGW +: TAGW]);
    end
  end

  // First requesting port at or after ptr, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = SRCW'((32'(ptr) + k) % NREQ);
      if (!gnt_any && bus.req_vld[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Every launched op owns a FIFO slot until popped, so the multiplier never stalls.
  assign credit_ok = (32'(fifo_cnt) + 32'($countones(pipe_vld))) < FDEPTH;
  assign grant     = gnt_any && credit_ok && run && !flush_now;
  assign ptr_nxt   = (gnt_idx == SRCW'(NREQ - 1)) ? '0 : gnt_idx + SRCW'(1);

  always_comb begin
    bus.req_rdy = '0;
    bus.mul_en  = 1'b0;
    bus.mul_op  = '0;
    bus.mul_R   = '0;
    bus.mul_C   = '0;
    sel_tag     = '0;
    if (grant) begin
      bus.req_rdy[gnt_idx] = 1'b1;
      bus.mul_en           = 1'b1;
      bus.mul_op           = reqs[gnt_idx].op;
      bus.mul_R            = reqs[gnt_idx].a;
      bus.mul_C            = reqs[gnt_idx].b;
      sel_tag              = TAGW'(reqs[gnt_idx].tag);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      ptr      <= '0;
      pipe_vld <= '0;
    end else begin
      run <= 1'b1;
      if (grant) ptr <= ptr_nxt;
      if (flush_now) pipe_vld <= '0;
      else           pipe_vld <= {pipe_vld[LAT-1:0], grant};
    end
  end

  assign bus.mul_clkEn = run;

  // Tag/source ride alongside the op; the result is held one cycle to meet its flags.
  always_ff @(posedge clk) begin
    pipe_tag[0] <= sel_tag;
    pipe_src[0] <= gnt_idx;
    for (int unsigned s = 1; s <= LAT; s++) begin
      pipe_tag[s] <= pipe_tag[s-1];
      pipe_src[s] <= pipe_src[s-1];
    end
    if (pipe_vld[LAT-1]) hold_res <= bus.mul_res;
  end

  imul_res_fifo #(
    .DEPTH (FDEPTH),
    .W     (DATW)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_now),
    .push  (pipe_vld[LAT]),
    .din   ({hold_res, bus.mul_flg, pipe_tag[LAT], pipe_src[LAT]}),
    .pop   (bus.out_rdy),
    .dout  (head),
    .vld   (bus.out_vld),
    .cnt   (fifo_cnt)
  );

  assign {bus.out_res, bus.out_flg, bus.out_tag, bus.out_src} = head;
  assign bus.busy = (|pipe_vld) || (fifo_cnt != '0);

endmodule

// File: tb/tb_imul_issue_arb.sv
// Directed bench for imul_issue_arb with a LAT-cycle multiplier model; covers IMUL_ARB_FLUSH_EN when defined.
module tb_imul_issue_arb;
  import imul_pkg::*;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned TAGW   = 9;
  localparam int unsigned LAT    = 4;
  localparam int unsigned FDEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
`ifdef IMUL_ARB_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  imul_issue_arb_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  imul_issue_arb #(
    .NREQ(NREQ), .TAGW(TAGW), .LAT(LAT), .FDEPTH(FDEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef IMUL_ARB_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  // Multiplier model: product after LAT cycles, flags {R[2:0],C[2:0]} one cycle later.
  logic [64:0] m_res [LAT];
  logic [5:0]  m_flg [LAT+1];
  always @(posedge clk) begin
    m_res[0] <= bus.mul_en ? 65'(bus.mul_R * bus.mul_C) : 65'h1_dead_beef;
    m_flg[0] <= bus.mul_en ? {bus.mul_R[2:0], bus.mul_C[2:0]} : 6'h3f;
    for (int i = 1; i < int'(LAT); i++) m_res[i] <= m_res[i-1];
    for (int i = 1; i <= int'(LAT); i++) m_flg[i] <= m_flg[i-1];
  end
  assign bus.mul_res = m_res[LAT-1];
  assign bus.mul_flg = m_flg[LAT];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [64:0] a, input logic [64:0] b,
                          input logic [8:0] tag, input logic [12:0] op);
    bus.req_vld[p]           = v;
    bus.req_A[p*65 +: 65]    = a;
    bus.req_B[p*65 +: 65]    = b;
    bus.req_tag[p*9 +: 9]    = tag;
    bus.req_op[p*13 +: 13]   = op;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req_vld = '0;
    bus.out_rdy = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  localparam logic [2:0] G2 [11] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000,
                                     3'b010, 3'b100, 3'b001, 3'b010};
  localparam logic [2:0] G3 [10] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000, 3'b000,
                                     3'b000, 3'b000, 3'b000};
  localparam logic [8:0] D_TAG [4] = '{9'd1, 9'd2, 9'd3, 9'd4};
  localparam logic [1:0] D_SRC [4] = '{2'd1, 2'd2, 2'd0, 2'd1};

  initial begin
    int k;
    int seq;
    logic [2:0] gp;
    logic found;

    bus.req_vld = '0;
    bus.req_op  = '0;
    bus.req_A   = '0;
    bus.req_B   = '0;
    bus.req_tag = '0;
    bus.out_rdy = 1'b0;

    // Reset state.
    #1;
    check("rst.req_rdy", bus.req_rdy, 0);
    check("rst.mul_en", bus.mul_en, 0);
    check("rst.mul_clkEn", bus.mul_clkEn, 0);
    check("rst.mul_op", bus.mul_op, 0);
    check("rst.mul_R", bus.mul_R, 0);
    check("rst.out_vld", bus.out_vld, 0);
    check("rst.busy", bus.busy, 0);
    do_reset();
    check("run.mul_clkEn", bus.mul_clkEn, 1);

    // Single op: 7*6 from port 0.
    set_port(0, 1'b1, 65'd7, 65'd6, 9'h055, 13'h0a5);
    #1;
    check("single.req_rdy", bus.req_rdy, 3'b001);
    check("single.mul_en", bus.mul_en, 1);
    check("single.mul_op", bus.mul_op, 13'h0a5);
    check("single.mul_R", bus.mul_R, 7);
    check("single.mul_C", bus.mul_C, 6);
    tick();
    bus.req_vld = '0;
    for (int t = 1; t <= 5; t++) begin
      check("single.early", bus.out_vld, 0);
      tick();
    end
    check("single.out_vld", bus.out_vld, 1);
    check("single.out_res", bus.out_res, 42);
    check("single.out_flg", bus.out_flg, 6'h3e);
    check("single.out_tag", bus.out_tag, 9'h055);
    check("single.out_src", bus.out_src, 0);
    check("single.busy", bus.busy, 1);
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    check("single.popped", bus.out_vld, 0);
    check("single.idle", bus.busy, 0);

    // All ports requesting, consumer always ready.
    do_reset();
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 65'(p + 2), 65'd10, 9'(9'h100 + p), 13'h0);
    bus.out_rdy = 1'b1;
    k = 0;
    for (int t = 0; t < 18; t++) begin
      bus.req_vld = (t < 11) ? 3'b111 : 3'b000;
      #1;
      check($sformatf("rr.gnt%0d", t), bus.req_rdy, (t < 11) ? G2[t] : 3'b000);
      check($sformatf("rr.ovld%0d", t), bus.out_vld, (t inside {6, 7, 8, 9, 13, 14, 15, 16}) ? 1 : 0);
      if (bus.out_vld && k < 8) begin
        check($sformatf("rr.src%0d", k), bus.out_src, k % 3);
        check($sformatf("rr.res%0d", k), bus.out_res, ((k % 3) + 2) * 10);
        check($sformatf("rr.tag%0d", k), bus.out_tag, 9'h100 + (k % 3));
        check($sformatf("rr.flg%0d", k), bus.out_flg, {3'((k % 3) + 2), 3'd2});
        k++;
      end
      tick();
    end
    check("rr.count", k, 8);
    bus.out_rdy = 1'b0;

    // Consumer stalled: exactly FDEPTH grants, then one pop frees exactly one grant.
    do_reset();
    seq = 0;
    for (int p = 0; p < 3; p++) begin
      set_port(p, 1'b1, 65'(seq + 1), 65'd3, 9'(seq), 13'h0);
      seq++;
    end
    for (int t = 0; t < 10; t++) begin
      #1;
      check($sformatf("full.gnt%0d", t), bus.req_rdy, G3[t]);
      gp = bus.req_rdy;
      tick();
      for (int p = 0; p < 3; p++)
        if (gp[p]) begin
          set_port(p, 1'b1, 65'(seq + 1), 65'd3, 9'(seq), 13'h0);
          seq++;
        end
    end
    check("full.out_vld", bus.out_vld, 1);
    check("full.head_tag", bus.out_tag, 0);
    check("full.head_src", bus.out_src, 0);
    check("full.busy", bus.busy, 1);
    bus.out_rdy = 1'b1;
    #1;
    check("full.pop_no_credit", bus.req_rdy, 0);
    tick();
    bus.out_rdy = 1'b0;
    #1;
    check("full.one_grant", bus.req_rdy, 3'b010);
    gp = bus.req_rdy;
    tick();
    #1;
    check("full.no_second", bus.req_rdy, 0);
    bus.req_vld = '0;
    bus.out_rdy = 1'b1;
    k = 0;
    for (int c = 0; c < 16; c++) begin
      if (bus.out_vld) begin
        if (k < 4) begin
          check($sformatf("drain.tag%0d", k), bus.out_tag, D_TAG[k]);
          check($sformatf("drain.src%0d", k), bus.out_src, D_SRC[k]);
          check($sformatf("drain.res%0d", k), bus.out_res, (D_TAG[k] + 1) * 3);
        end else begin
          check("drain.extra", bus.out_tag, 9'h1ff);
        end
        k++;
      end
      tick();
    end
    check("drain.count", k, 4);
    check("drain.busy", bus.busy, 0);
    bus.out_rdy = 1'b0;

    // Reset with three ops in flight.
    do_reset();
    set_port(0, 1'b1, 65'd9, 65'd9, 9'h0aa, 13'h0);
    for (int t = 0; t < 3; t++) begin
      #1;
      check($sformatf("rstmid.launch%0d", t), bus.mul_en, 1);
      tick();
    end
    rst = 1'b0;
    #1;
    check("rstmid.out_vld", bus.out_vld, 0);
    check("rstmid.busy", bus.busy, 0);
    check("rstmid.req_rdy", bus.req_rdy, 0);
    check("rstmid.mul_en", bus.mul_en, 0);
    check("rstmid.clkEn", bus.mul_clkEn, 0);
    repeat (2) tick();
    bus.req_vld = '0;
    rst = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      check($sformatf("rstmid.late%0d", t), bus.out_vld, 0);
      check($sformatf("rstmid.bsy%0d", t), bus.busy, 0);
    end

`ifdef IMUL_ARB_FLUSH_EN
    // Flush with two buffered and two in flight.
    do_reset();
    set_port(0, 1'b1, 65'd5, 65'd5, 9'h01a, 13'h0);
    for (int t = 0; t < 2; t++) begin
      #1;
      check($sformatf("fl.gnt%0d", t), bus.req_rdy, 3'b001);
      tick();
    end
    bus.req_vld = '0;
    repeat (3) tick();
    bus.req_vld = 3'b001;
    for (int t = 0; t < 2; t++) begin
      #1;
      check($sformatf("fl.gnt_late%0d", t), bus.req_rdy, 3'b001);
      tick();
    end
    flush = 1'b1;
    #1;
    check("fl.suppress", bus.req_rdy, 0);
    check("fl.pre_vld", bus.out_vld, 1);
    check("fl.pre_busy", bus.busy, 1);
    tick();
    flush = 1'b0;
    bus.req_vld = '0;
    #1;
    check("fl.out_vld", bus.out_vld, 0);
    check("fl.busy", bus.busy, 0);
    set_port(0, 1'b1, 65'd7, 65'd6, 9'h077, 13'h0);
    #1;
    check("fl.new_gnt", bus.req_rdy, 3'b001);
    tick();
    bus.req_vld = '0;
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      if (bus.out_vld) found = 1'b1;
      else tick();
    end
    check("fl.found", found, 1);
    check("fl.tag", bus.out_tag, 9'h077);
    check("fl.res", bus.out_res, 42);
    bus.out_rdy = 1'b1;
    tick();
    bus.out_rdy = 1'b0;
    check("fl.idle", bus.busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
